// File: rtl/registro_instruccion.sv
// Instruction register with fetch handshake, timeout and entry-state decode.
// The fetch FSM captures memory data, registers the control-unit entry state
// one cycle later, and keeps a small condition register (CR) plus a
// registered status flag used by class-101 conditional decodes.
module registro_instruccion (
   input  logic        Reloj,
   input  logic        Reiniciar,
   input  logic [15:0] BusDatos,
   input  logic        MemListo,
   input  logic        LoadIR,
   input  logic        LoadCR,
   input  logic [3:0]  Flags,
   input  logic        LoadS,
   input  logic [1:0]  SelectS,
   input  logic        NegS,
   output logic [15:0] Instruccion,
   output logic [5:0]  EntraEstado,
   output logic        StatusFlag,
   output logic        IRValido,
   output logic        Espera,
   output logic        ErrorBus,
   output logic        Ilegal
);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ESPERA = 2'd1,
      DECOD  = 2'd2,
      LISTO  = 2'd3
   } estado_t;

   estado_t     estado_r;
   estado_t     estadoSig_s;
   logic [3:0]  contEspera_r;
   logic [15:0] instruccion_r;
   logic [5:0]  entraEstado_r;
   logic        statusFlag_r;
   logic        irValido_r;
   logic        errorBus_r;
   logic        ilegal_r;
   logic [3:0]  cr_r;

   logic        espera_s;
   logic        inicioFetch_s;
   logic        captura_s;
   logic        cargaCont_s;
   logic        incCont_s;
   logic        timeout_s;
   logic        decodifica_s;
   logic [6:0]  decod_s;

   // Entry-state decode: bit 6 flags an illegal opcode, bits 5:0 the entry state.
   function automatic logic [6:0] decodificar(input logic [15:0] instr, input logic flag);
      logic [6:0] res;
      res = {1'b1, 6'd0};
      case (instr[15:13])
         3'b000: res = {1'b0, 6'd3};
         3'b001: res = {1'b0, 6'd7};
         3'b010: begin
            if (instr[12]) begin
               res = {1'b0, 6'd6};
            end else begin
               res = {1'b0, 6'd5};
            end
         end
         3'b011: begin
            case (instr[12:11])
               2'b00:   res = {1'b0, 6'd8};
               2'b01:   res = {1'b0, 6'd9};
               2'b10:   res = {1'b0, 6'd13};
               2'b11:   res = {1'b0, 6'd19};
               default: res = {1'b1, 6'd0};
            endcase
         end
         3'b100: begin
            case (instr[12:11])
               2'b01:   res = {1'b0, 6'd11};
               2'b10:   res = {1'b0, 6'd16};
               2'b11:   res = {1'b0, 6'd22};
               default: res = {1'b1, 6'd0};
            endcase
         end
         3'b101: begin
            if (instr[12] && !flag) begin
               res = {1'b0, 6'd25};
            end else begin
               res = {1'b0, 6'd26};
            end
         end
         3'b110:  res = {1'b0, 6'd27};
         3'b111:  res = {1'b0, 6'd31};
         default: res = {1'b1, 6'd0};
      endcase
      return res;
   endfunction

   // FSM state register.
   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         estado_r <= REPOSO;
      end else begin
         estado_r <= estadoSig_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      estadoSig_s = estado_r;
      case (estado_r)
         REPOSO, LISTO: begin
            if (LoadIR) begin
               if (MemListo) begin
                  estadoSig_s = DECOD;
               end else begin
                  estadoSig_s = ESPERA;
               end
            end else begin
               estadoSig_s = estado_r;
            end
         end
         ESPERA: begin
            if (MemListo) begin
               estadoSig_s = DECOD;
            end else if (contEspera_r == 4'd15) begin
               estadoSig_s = REPOSO;
            end else begin
               estadoSig_s = ESPERA;
            end
         end
         DECOD:   estadoSig_s = LISTO;
         default: estadoSig_s = REPOSO;
      endcase
   end

   // FSM outputs: stall indication and datapath control strobes.
   always_comb begin
      espera_s      = 1'b0;
      inicioFetch_s = 1'b0;
      captura_s     = 1'b0;
      cargaCont_s   = 1'b0;
      incCont_s     = 1'b0;
      timeout_s     = 1'b0;
      decodifica_s  = 1'b0;
      case (estado_r)
         REPOSO, LISTO: begin
            if (LoadIR) begin
               inicioFetch_s = 1'b1;
               if (MemListo) begin
                  captura_s = 1'b1;
               end else begin
                  cargaCont_s = 1'b1;
               end
            end else begin
               inicioFetch_s = 1'b0;
            end
         end
         ESPERA: begin
            espera_s = 1'b1;
            if (MemListo) begin
               captura_s = 1'b1;
            end else if (contEspera_r == 4'd15) begin
               timeout_s = 1'b1;
            end else begin
               incCont_s = 1'b1;
            end
         end
         DECOD:   decodifica_s = 1'b1;
         default: decodifica_s = 1'b0;
      endcase
   end

   assign decod_s = decodificar(instruccion_r, statusFlag_r);

   // Fetch datapath: instruction capture, wait counter, decode and pulses.
   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         instruccion_r <= 16'h0000;
         contEspera_r  <= 4'd0;
         entraEstado_r <= 6'd0;
         irValido_r    <= 1'b0;
         errorBus_r    <= 1'b0;
         ilegal_r      <= 1'b0;
      end else begin
         if (captura_s) begin
            instruccion_r <= BusDatos;
         end
         if (cargaCont_s) begin
            contEspera_r <= 4'd0;
         end else if (incCont_s) begin
            contEspera_r <= contEspera_r + 4'd1;
         end
         if (decodifica_s) begin
            entraEstado_r <= decod_s[5:0];
         end
         if (inicioFetch_s) begin
            irValido_r <= 1'b0;
         end else if (decodifica_s) begin
            irValido_r <= 1'b1;
         end
         errorBus_r <= timeout_s;
         ilegal_r   <= decodifica_s & decod_s[6];
      end
   end

   // Condition register and status flag; LoadS always sees the pre-edge CR.
   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         cr_r         <= 4'h0;
         statusFlag_r <= 1'b0;
      end else begin
         if (LoadCR) begin
            cr_r <= Flags;
         end
         if (LoadS) begin
            statusFlag_r <= cr_r[SelectS] ^ NegS;
         end
      end
   end

   assign Instruccion = instruccion_r;
   assign EntraEstado = entraEstado_r;
   assign StatusFlag  = statusFlag_r;
   assign IRValido    = irValido_r;
   assign Espera      = espera_s;
   assign ErrorBus    = errorBus_r;
   assign Ilegal      = ilegal_r;

endmodule

// File: tb/tb_registro_instruccion.sv
// Scoreboard bench for registro_instruccion: stimulus pushes the expected
// outcome of each fetch, a negedge monitor pops it when the DUT reports
// completion (IRValido rising or ErrorBus).
module tb_registro_instruccion;

   logic        Reloj = 1'b0;
   logic        Reiniciar;
   logic [15:0] BusDatos;
   logic        MemListo;
   logic        LoadIR;
   logic        LoadCR;
   logic [3:0]  Flags;
   logic        LoadS;
   logic [1:0]  SelectS;
   logic        NegS;
   logic [15:0] Instruccion;
   logic [5:0]  EntraEstado;
   logic        StatusFlag;
   logic        IRValido;
   logic        Espera;
   logic        ErrorBus;
   logic        Ilegal;

   registro_instruccion dut (
      .Reloj(Reloj), .Reiniciar(Reiniciar), .BusDatos(BusDatos), .MemListo(MemListo),
      .LoadIR(LoadIR), .LoadCR(LoadCR), .Flags(Flags), .LoadS(LoadS),
      .SelectS(SelectS), .NegS(NegS), .Instruccion(Instruccion),
      .EntraEstado(EntraEstado), .StatusFlag(StatusFlag), .IRValido(IRValido),
      .Espera(Espera), .ErrorBus(ErrorBus), .Ilegal(Ilegal)
   );

   always #5 Reloj = ~Reloj;

   typedef struct {
      logic        tOut;
      logic [15:0] instr;
      logic [5:0]  entra;
      logic        ileg;
      logic        sf;
      int          esp;
   } exp_t;

   exp_t q[$];
   int nChecks = 0;
   int nFails  = 0;
   int issued  = 0;
   int done    = 0;

   // reference model state
   logic [15:0] mInstr = 16'h0000;
   logic [5:0]  mEntra = 6'd0;
   logic [3:0]  mCr    = 4'h0;
   logic        mSf    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // entry state from the decode table; -1 means illegal
   function automatic int modelDecode(input logic [15:0] d, input logic sf);
      int cls;
      int mode;
      int t011[4];
      int t100[4];
      cls  = int'(d[15:13]);
      mode = int'(d[12:11]);
      t011 = '{8, 9, 13, 19};
      t100 = '{-1, 11, 16, 22};
      case (cls)
         0:       return 3;
         1:       return 7;
         2:       return d[12] ? 6 : 5;
         3:       return t011[mode];
         4:       return t100[mode];
         5:       return (d[12] && !sf) ? 25 : 26;
         6:       return 27;
         default: return 31;
      endcase
   endfunction

   // Monitor: pop and compare on each completion event.
   int   esperaCnt = 0;
   logic prevValid = 1'b0;
   logic pulseChk  = 1'b0;
   always @(negedge Reloj) begin
      exp_t e;
      if (!Reiniciar) begin
         esperaCnt = 0;
         prevValid = 1'b0;
         pulseChk  = 1'b0;
      end else begin
         if (pulseChk) begin
            chk("ErrorBus_width", 32'(ErrorBus), 32'd0);
            chk("Ilegal_width", 32'(Ilegal), 32'd0);
            pulseChk = 1'b0;
         end
         if (Espera) esperaCnt++;
         if ((IRValido && !prevValid) || ErrorBus) begin
            if (q.size() == 0) begin
               chk("unexpected_event", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("ErrorBus", 32'(ErrorBus), 32'(e.tOut));
               chk("IRValido", 32'(IRValido), 32'(!e.tOut));
               chk("Instruccion", 32'(Instruccion), 32'(e.instr));
               chk("EntraEstado", 32'(EntraEstado), 32'(e.entra));
               chk("Ilegal", 32'(Ilegal), 32'(e.ileg));
               chk("StatusFlag", 32'(StatusFlag), 32'(e.sf));
               chk("Espera_cycles", 32'(esperaCnt), 32'(e.esp));
            end
            pulseChk  = 1'b1;
            esperaCnt = 0;
            done++;
         end
         prevValid = IRValido;
      end
   end

   // One fetch: lat cycles with MemListo=0 before data; lat>16 times out.
   task automatic fetch(input logic [15:0] d, input int lat);
      exp_t e;
      int   code;
      int   nEsp;
      int   target;
      logic ok;
      ok = (lat <= 16);
      e.sf = mSf;
      if (ok) begin
         code    = modelDecode(d, mSf);
         e.tOut  = 1'b0;
         e.instr = d;
         e.ileg  = (code < 0);
         e.entra = (code < 0) ? 6'd0 : 6'(code);
         e.esp   = lat;
         mInstr  = d;
         mEntra  = e.entra;
      end else begin
         e.tOut  = 1'b1;
         e.instr = mInstr;
         e.entra = mEntra;
         e.ileg  = 1'b0;
         e.esp   = 16;
      end
      q.push_back(e);
      issued++;
      target = issued;
      nEsp = ok ? lat : 16;
      @(posedge Reloj); #1;
      LoadIR   = 1'b1;
      MemListo = (lat == 0);
      BusDatos = (lat == 0) ? d : 16'($urandom);
      for (int k = 1; k <= nEsp; k++) begin
         @(posedge Reloj); #1;
         LoadIR   = 1'($urandom);
         MemListo = (k == lat);
         BusDatos = (k == lat) ? d : 16'($urandom);
         LoadCR   = 1'($urandom);
         Flags    = 4'($urandom);
         if (LoadCR) mCr = Flags;
      end
      if (ok) begin
         @(posedge Reloj); #1;
         LoadIR   = 1'($urandom);
         MemListo = 1'($urandom);
         BusDatos = 16'($urandom);
         LoadCR   = 1'b0;
      end
      @(posedge Reloj); #1;
      LoadIR   = 1'b0;
      LoadCR   = 1'b0;
      MemListo = 1'b0;
      for (int w = 0; w < 40 && done < target; w++) @(negedge Reloj);
      if (done < target) chk("fetch_timeout", 32'(done), 32'(target));
   endtask

   task automatic crOp(input logic lcr, input logic [3:0] f, input logic ls,
                       input logic [1:0] sel, input logic neg);
      @(posedge Reloj); #1;
      LoadCR = lcr; Flags = f; LoadS = ls; SelectS = sel; NegS = neg;
      if (ls) mSf = mCr[sel] ^ neg;
      if (lcr) mCr = f;
      @(posedge Reloj); #1;
      LoadCR = 1'b0; LoadS = 1'b0;
   endtask

   initial begin
      int r;
      int lat;
      Reiniciar = 1'b0;
      BusDatos = 16'h0000; MemListo = 1'b0; LoadIR = 1'b0; LoadCR = 1'b0;
      Flags = 4'h0; LoadS = 1'b0; SelectS = 2'd0; NegS = 1'b0;
      repeat (3) @(posedge Reloj);
      #1;
      chk("rst_Instruccion", 32'(Instruccion), 32'd0);
      chk("rst_EntraEstado", 32'(EntraEstado), 32'd0);
      chk("rst_flags", {25'd0, StatusFlag, IRValido, Espera, ErrorBus, Ilegal, 2'd0}, 32'd0);
      Reiniciar = 1'b1;

      // directed cases
      fetch(16'h6800, 0);                 // entry 9
      fetch(16'h0000, 3);                 // three stall cycles, entry 3
      fetch(16'h1234, 17);                // timeout, instruction kept
      fetch(16'h4000, 16);                // longest successful wait
      crOp(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
      crOp(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);   // StatusFlag = 1
      fetch(16'hB000, 0);                 // 26
      crOp(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);   // StatusFlag = 0
      fetch(16'hB000, 1);                 // 25
      fetch(16'h8000, 0);                 // illegal
      crOp(1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
      crOp(1'b1, 4'b1110, 1'b1, 2'd0, 1'b1);   // old CR[0]=0 -> 1
      fetch(16'hB800, 2);                 // flag 1 -> 26

      // reset in the middle of a stalled fetch
      @(posedge Reloj); #1;
      LoadIR = 1'b1; MemListo = 1'b0;
      @(posedge Reloj); #1;
      LoadIR = 1'b0;
      repeat (3) @(posedge Reloj);
      #2;
      Reiniciar = 1'b0;
      #1;
      chk("arst_Instruccion", 32'(Instruccion), 32'd0);
      chk("arst_EntraEstado", 32'(EntraEstado), 32'd0);
      chk("arst_flags", {25'd0, StatusFlag, IRValido, Espera, ErrorBus, Ilegal, 2'd0}, 32'd0);
      mInstr = 16'h0000; mEntra = 6'd0; mCr = 4'h0; mSf = 1'b0;
      @(posedge Reloj); #1;
      Reiniciar = 1'b1;
      repeat (24) @(posedge Reloj);   // any ErrorBus here is flagged by the monitor

      // randomized fetches and CR operations
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)      lat = int'($urandom_range(0, 4));
         else if (r < 8) lat = int'($urandom_range(5, 16));
         else            lat = 17;
         fetch(16'($urandom), lat);
         if ($urandom_range(0, 1) == 1)
            crOp(1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      end

      repeat (4) @(posedge Reloj);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/registro_instruccion.md
REGISTRO_INSTRUCCION -- requirements
Module: registro_instruccion

Interface
REQ-001 SHALL have port Reloj, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port Reiniciar, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port BusDatos, input, 16 bits: memory read data.
REQ-004 SHALL have port MemListo, input, 1 bit: memory data valid this cycle.
REQ-005 SHALL have port LoadIR, input, 1 bit: fetch request from control unit.
REQ-006 SHALL have port LoadCR, input, 1 bit: load condition register from Flags.
REQ-007 SHALL have port Flags, input, 4 bits: ALU flags {V,C,N,Z}, bit 0 = Z.
REQ-008 SHALL have ports LoadS (1 bit), SelectS (2 bits) and NegS (1 bit), all inputs: status-flag load, CR bit select, invert.
REQ-009 SHALL have port Instruccion, output, 16 bits: held instruction.
REQ-010 SHALL have port EntraEstado, output, 6 bits: decoded entry state for the control unit.
REQ-011 SHALL have port StatusFlag, output, 1 bit: registered condition result.
REQ-012 SHALL have port IRValido, output, 1 bit: Instruccion/EntraEstado valid.
REQ-013 SHALL have ports Espera, ErrorBus and Ilegal, outputs, 1 bit each: fetch stalled; fetch timeout pulse; illegal opcode pulse.

Function
REQ-014 SHALL implement FSM states REPOSO, ESPERA, DECOD, LISTO.
REQ-015 REPOSO/LISTO + LoadIR + MemListo: SHALL capture BusDatos into Instruccion on that edge, clear IRValido, and go to DECOD.
REQ-016 REPOSO/LISTO + LoadIR + !MemListo: SHALL go to ESPERA, clear IRValido, and load the 4-bit wait counter with 0.
REQ-017 In ESPERA, Espera SHALL be 1 (combinational from state); in all other states it SHALL be 0.
REQ-018 In ESPERA + MemListo: SHALL capture BusDatos and go to DECOD.
REQ-019 In ESPERA + !MemListo: the counter SHALL increment; with counter = 15 and !MemListo, SHALL pulse ErrorBus for 1 cycle, keep the old Instruccion, and return to REPOSO.
REQ-020 LoadIR asserted in ESPERA or DECOD SHALL be ignored.
REQ-021 In DECOD: SHALL register EntraEstado from Instruccion, set IRValido=1, and go to LISTO (EntraEstado valid 1 cycle after capture).
REQ-022 Decode class Instruccion[15:13], mode [12:11], by class:
  000 -> 3.
  001 -> 7.
  010 -> [12]=0 ? 5 : 6.
  011 -> mode 00/01/10/11 -> 8/9/13/19.
  100 -> mode 01/10/11 -> 11/16/22; mode 00 -> illegal.
  101 -> [12]=0 ? 26 : (StatusFlag ? 26 : 25).
  110 -> 27.
  111 -> 31.
REQ-023 Illegal decode SHALL set EntraEstado=0, pulse Ilegal for 1 cycle, and still set IRValido=1.
REQ-024 Class-101 decode SHALL use the StatusFlag value registered before the DECOD edge.
REQ-025 LoadCR SHALL load a 4-bit CR from Flags on the edge, in any FSM state.
REQ-026 LoadS SHALL register StatusFlag <= CR[SelectS] ^ NegS using the pre-edge CR value; with LoadCR and LoadS in the same cycle, the old CR SHALL be used.
REQ-027 Instruccion, EntraEstado and StatusFlag SHALL hold their values when not loaded.

Reset
REQ-028 Reiniciar=0 SHALL immediately force:
  - state REPOSO, counter 0;
  - Instruccion=16'h0000, EntraEstado=6'd0, CR=4'h0;
  - StatusFlag, IRValido, Espera, ErrorBus and Ilegal all 0.
REQ-029 Reset during ESPERA or DECOD SHALL abort the fetch with no ErrorBus or Ilegal pulse.
REQ-030 After reset release, the first rising edge SHALL evaluate from REPOSO.

Verification
REQ-031 LoadIR with MemListo=1, BusDatos=16'h6800 -> next cycle Instruccion=16'h6800; one cycle later EntraEstado=9, IRValido=1.
REQ-032 LoadIR with MemListo=0 for 3 cycles, then 1 with BusDatos=16'h0000 -> Espera=1 for exactly 3 cycles; then EntraEstado=3.
REQ-033 LoadIR with MemListo held 0 -> ErrorBus pulses once after 16 ESPERA cycles; state REPOSO; Instruccion unchanged.
REQ-034 Flags=4'b0001 with LoadCR, then LoadS with SelectS=0, NegS=0 -> StatusFlag=1; fetch 16'hB000 -> EntraEstado=26; repeat with NegS=1 -> EntraEstado=25.
REQ-035 Fetch 16'h8000 -> EntraEstado=0, Ilegal pulses 1 cycle; then LoadCR+LoadS in the same cycle -> StatusFlag is computed from the old CR.
REQ-036 Reiniciar=0 asserted mid-ESPERA -> all outputs 0 asynchronously; no ErrorBus pulse.
